cpu_ctrl_fsm: RTL and testbench

CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/cpu_ctrl_fsm_if.sv | 32 +++
 rtl/cpu_alu.sv | 13 +
 rtl/cpu_ctrl_fsm.sv | 162 ++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU controller: opcodes, FSM state
// encoding, instruction field positions and an instruction encoder.
package cpu_pkg;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_LDI  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_HALT = 4'h7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEMRD,
    S_HALT
  } state_e;

  function automatic logic [15:0] encode(input logic [3:0] op, input logic [1:0] rd,
                                         input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Instruction-memory, data-memory and register-file bus of the CPU controller;
// master is the controller side, slave is the memory/register-file side.
interface cpu_ctrl_fsm_if;

  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        dmem_cs;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic [7:0]  dmem_rdata;
  logic [1:0]  rf_raddr_a;
  logic [1:0]  rf_raddr_b;
  logic [7:0]  rf_rdata_a;
  logic [7:0]  rf_rdata_b;
  logic        rf_we;
  logic [1:0]  rf_waddr;
  logic [7:0]  rf_wdata;

  modport master (
    output imem_addr, dmem_cs, dmem_we, dmem_addr, dmem_wdata,
           rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
    input  imem_rdata, dmem_rdata, rf_rdata_a, rf_rdata_b
  );

  modport slave (
    input  imem_addr, dmem_cs, dmem_we, dmem_addr, dmem_wdata,
           rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
    output imem_rdata, dmem_rdata, rf_rdata_a, rf_rdata_b
  );

endinterface

// File: rtl/cpu_alu.sv
// Combinational 8-bit add/subtract with zero detect; carry and borrow are dropped.
module cpu_alu (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sub,
  output logic [7:0] result,
  output logic       zero
);

  assign result = sub ? (a - b) : (a + b);
  assign zero   = (result == 8'h00);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle controller: FETCH/DECODE/EXEC (+MEMRD for loads) over external
// instruction memory, data memory and a 4x8 register file.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  output logic        dmem_cs,
  output logic        dmem_we,
  output logic [7:0]  dmem_addr,
  output logic [7:0]  dmem_wdata,
  input  logic [7:0]  dmem_rdata,
  output logic [1:0]  rf_raddr_a,
  output logic [1:0]  rf_raddr_b,
  input  logic [7:0]  rf_rdata_a,
  input  logic [7:0]  rf_rdata_b,
  output logic        rf_we,
  output logic [1:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  output logic [7:0]  pc,
  output logic        busy,
  output logic        halted,
  output logic        zero_flag
);

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        zero_q, zero_d;

  logic [3:0]  op;
  logic [1:0]  rd;
  logic [1:0]  rs;
  logic [7:0]  imm;
  logic [7:0]  alu_result;
  logic        alu_zero;

  assign op  = ir_q[OP_MSB:OP_LSB];
  assign rd  = ir_q[RD_MSB:RD_LSB];
  assign rs  = ir_q[RS_MSB:RS_LSB];
  assign imm = ir_q[IMM_MSB:IMM_LSB];

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign rf_raddr_a = rd;
  assign rf_raddr_b = rs;
  assign zero_flag  = zero_q;

  cpu_alu u_alu (
    .a      (rf_rdata_a),
    .b      (rf_rdata_b),
    .sub    (op == OP_SUB),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zero_q  <= zero_d;
    end
  end

  // All enables are decoded from the registered state, so an async reset
  // removes them in the same instant the state register clears.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    zero_d     = zero_q;
    dmem_cs    = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 8'h00;
    dmem_wdata = 8'h00;
    rf_we      = 1'b0;
    rf_waddr   = 2'd0;
    rf_wdata   = 8'h00;
    busy       = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
        end
      end
      S_FETCH: begin
        busy    = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        busy    = 1'b1;
        ir_d    = imem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        busy    = 1'b1;
        state_d = S_FETCH;
        pc_d    = pc_q + 8'd1;
        case (op)
          OP_LDI: begin
            rf_we    = 1'b1;
            rf_waddr = rd;
            rf_wdata = imm;
          end
          OP_ADD, OP_SUB: begin
            rf_we    = 1'b1;
            rf_waddr = rd;
            rf_wdata = alu_result;
            zero_d   = alu_zero;
          end
          OP_LD: begin
            dmem_cs   = 1'b1;
            dmem_addr = imm;
            state_d   = S_MEMRD;
          end
          OP_ST: begin
            dmem_cs    = 1'b1;
            dmem_we    = 1'b1;
            dmem_addr  = imm;
            dmem_wdata = rf_rdata_a;
          end
          OP_JMP: pc_d = imm;
          OP_JZ: begin
            if (zero_q) pc_d = imm;
          end
          OP_HALT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_MEMRD: begin
        busy     = 1'b1;
        rf_we    = 1'b1;
        rf_waddr = rd;
        rf_wdata = dmem_rdata;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
          zero_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm with memory/register-file models and a
// write scoreboard filled as each program is loaded.
module tb_cpu_ctrl_fsm;
  import cpu_pkg::*;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } rf_wr_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } dm_wr_t;

  logic clk;
  logic reset;
  logic start;
  logic [7:0] pc;
  logic busy;
  logic halted;
  logic zero_flag;

  cpu_ctrl_fsm_if bus ();

  logic [15:0] imem [0:255];
  logic [7:0]  dmem [0:255];
  logic [7:0]  rf   [0:3];

  rf_wr_t rf_exp[$];
  dm_wr_t dm_exp[$];

  logic [7:0] pc_hist   [0:255];
  logic       zero_hist [0:255];
  logic       busy_hist [0:255];

  int checks = 0;
  int errors = 0;
  int n;

  cpu_ctrl_fsm #(.RESET_PC(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .imem_addr  (bus.imem_addr),
    .imem_rdata (bus.imem_rdata),
    .dmem_cs    (bus.dmem_cs),
    .dmem_we    (bus.dmem_we),
    .dmem_addr  (bus.dmem_addr),
    .dmem_wdata (bus.dmem_wdata),
    .dmem_rdata (bus.dmem_rdata),
    .rf_raddr_a (bus.rf_raddr_a),
    .rf_raddr_b (bus.rf_raddr_b),
    .rf_rdata_a (bus.rf_rdata_a),
    .rf_rdata_b (bus.rf_rdata_b),
    .rf_we      (bus.rf_we),
    .rf_waddr   (bus.rf_waddr),
    .rf_wdata   (bus.rf_wdata),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .zero_flag  (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory and register-file models: registered memory reads, combinational RF reads.
  always @(posedge clk) begin
    bus.imem_rdata <= imem[bus.imem_addr];
    if (bus.dmem_cs && !bus.dmem_we) bus.dmem_rdata <= dmem[bus.dmem_addr];
    if (bus.dmem_cs && bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
    if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
  end

  assign bus.rf_rdata_a = rf[bus.rf_raddr_a];
  assign bus.rf_rdata_b = rf[bus.rf_raddr_b];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write the DUT issues must match the next queued one.
  always @(negedge clk) begin
    if (bus.rf_we) begin
      checks++;
      assert (rf_exp.size() != 0)
      else begin
        errors++;
        $error("FAIL rf_unexpected_write: observed R%0d=0x%0h required none", bus.rf_waddr, bus.rf_wdata);
      end
      if (rf_exp.size() != 0) begin
        rf_wr_t e;
        e = rf_exp.pop_front();
        check("rf_write", {22'd0, bus.rf_waddr, bus.rf_wdata}, {22'd0, e.addr, e.data});
        $display("rf write   R%0d <= 0x%02h", bus.rf_waddr, bus.rf_wdata);
      end
    end
    if (bus.dmem_cs && bus.dmem_we) begin
      checks++;
      assert (dm_exp.size() != 0)
      else begin
        errors++;
        $error("FAIL dmem_unexpected_write: observed [0x%0h]=0x%0h required none", bus.dmem_addr, bus.dmem_wdata);
      end
      if (dm_exp.size() != 0) begin
        dm_wr_t d;
        d = dm_exp.pop_front();
        check("dmem_write", {16'd0, bus.dmem_addr, bus.dmem_wdata}, {16'd0, d.addr, d.data});
        $display("dmem write [0x%02h] <= 0x%02h", bus.dmem_addr, bus.dmem_wdata);
      end
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h8000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Pulses start, then counts edges until halted (or max_n), recording pc/zero/busy
  // after each edge; start is raised again after edge poke_at to probe it is ignored.
  task automatic run(input int poke_at, input int max_n, output int cnt);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    pc_hist[0] = pc;
    zero_hist[0] = zero_flag;
    busy_hist[0] = busy;
    while (!halted && cnt < max_n) begin
      if (cnt == poke_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt++;
      pc_hist[cnt] = pc;
      zero_hist[cnt] = zero_flag;
      busy_hist[cnt] = busy;
    end
    $display("run: %0d cycles, pc=0x%02h halted=%0d", cnt, pc, halted);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    clear_imem();
    repeat (3) @(negedge clk);
    check("reset_pc", pc, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_halted", halted, 1'b0);
    check("reset_zero", zero_flag, 1'b0);
    check("reset_rf_we", bus.rf_we, 1'b0);
    check("reset_dmem_cs", bus.dmem_cs, 1'b0);
    check("reset_ir_rd", bus.rf_raddr_a, 2'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_idle_busy", busy, 1'b0);
    check("post_reset_idle_pc", pc, 8'h00);

    // LDI/LDI/ADD
    clear_imem();
    imem[0] = encode(OP_LDI, 2'd1, 2'd0, 8'h02);
    imem[1] = encode(OP_LDI, 2'd2, 2'd0, 8'h04);
    imem[2] = encode(OP_ADD, 2'd1, 2'd2, 8'h00);
    imem[3] = encode(OP_HALT, 2'd0, 2'd0, 8'h00);
    rf_exp.push_back('{2'd1, 8'h02});
    rf_exp.push_back('{2'd2, 8'h04});
    rf_exp.push_back('{2'd1, 8'h06});
    run(-1, 100, n);
    check("add_cycles", n, 12);
    check("add_pc_at9", pc_hist[9], 8'h03);
    check("add_zero_at9", zero_hist[9], 1'b0);
    check("add_r1", rf[1], 8'h06);

    // SUB to zero then taken JZ
    do_reset();
    clear_imem();
    imem[0] = encode(OP_LDI, 2'd1, 2'd0, 8'h05);
    imem[1] = encode(OP_LDI, 2'd2, 2'd0, 8'h05);
    imem[2] = encode(OP_SUB, 2'd1, 2'd2, 8'h00);
    imem[3] = encode(OP_JZ, 2'd0, 2'd0, 8'h20);
    imem[4] = encode(OP_LDI, 2'd3, 2'd0, 8'hEE);
    imem[8'h20] = encode(OP_HALT, 2'd0, 2'd0, 8'h00);
    rf_exp.push_back('{2'd1, 8'h05});
    rf_exp.push_back('{2'd2, 8'h05});
    rf_exp.push_back('{2'd1, 8'h00});
    run(-1, 100, n);
    check("jz_cycles", n, 15);
    check("jz_pc_at12", pc_hist[12], 8'h20);
    check("jz_zero_at12", zero_hist[12], 1'b1);
    check("jz_halt_pc", pc, 8'h21);
    check("jz_r1", rf[1], 8'h00);

    // ST then LD of the same address, then a not-taken JZ
    do_reset();
    clear_imem();
    imem[0] = encode(OP_LDI, 2'd1, 2'd0, 8'hA5);
    imem[1] = encode(OP_ST, 2'd1, 2'd0, 8'h06);
    imem[2] = encode(OP_LD, 2'd3, 2'd0, 8'h06);
    imem[3] = encode(OP_JZ, 2'd0, 2'd0, 8'h40);
    imem[4] = encode(OP_HALT, 2'd0, 2'd0, 8'h00);
    imem[8'h40] = encode(OP_LDI, 2'd0, 2'd0, 8'h99);
    rf_exp.push_back('{2'd1, 8'hA5});
    dm_exp.push_back('{8'h06, 8'hA5});
    rf_exp.push_back('{2'd3, 8'hA5});
    run(-1, 100, n);
    check("ldst_cycles", n, 16);
    check("ld_pc_at9", pc_hist[9], 8'h03);
    check("ld_memrd_pc_at10", pc_hist[10], 8'h03);
    check("ld_busy_at10", busy_hist[10], 1'b1);
    check("ldst_halt_pc", pc, 8'h05);
    check("st_mem", dmem[6], 8'hA5);
    check("ld_r3", rf[3], 8'hA5);

    // JMP 0xFF then NOP wraps the PC
    do_reset();
    clear_imem();
    imem[0] = encode(OP_JMP, 2'd0, 2'd0, 8'hFF);
    imem[8'hFF] = 16'h8000;
    run(-1, 7, n);
    check("jmp_pc_at3", pc_hist[3], 8'hFF);
    check("wrap_pc_at6", pc_hist[6], 8'h00);
    check("wrap_not_halted", halted, 1'b0);

    // HALT at 0x04, start while busy ignored, restart from HALT
    do_reset();
    clear_imem();
    imem[0] = encode(OP_LDI, 2'd0, 2'd0, 8'h11);
    imem[1] = encode(OP_SUB, 2'd0, 2'd0, 8'h00);
    imem[2] = 16'h9000;
    imem[3] = 16'hF123;
    imem[4] = encode(OP_HALT, 2'd0, 2'd0, 8'h00);
    rf_exp.push_back('{2'd0, 8'h11});
    rf_exp.push_back('{2'd0, 8'h00});
    run(4, 100, n);
    check("halt_cycles", n, 15);
    check("halt_pc", pc, 8'h05);
    check("halt_busy", busy, 1'b0);
    check("halt_halted", halted, 1'b1);
    check("halt_zero", zero_flag, 1'b1);
    rf_exp.push_back('{2'd0, 8'h11});
    rf_exp.push_back('{2'd0, 8'h00});
    run(-1, 100, n);
    check("restart_pc", pc_hist[0], 8'h00);
    check("restart_zero_cleared", zero_hist[0], 1'b0);
    check("restart_busy", busy_hist[0], 1'b1);
    check("restart_cycles", n, 15);

    // Reset asserted during the EXEC of a store
    do_reset();
    clear_imem();
    imem[0] = encode(OP_LDI, 2'd1, 2'd0, 8'h5A);
    imem[1] = encode(OP_ST, 2'd1, 2'd0, 8'h30);
    imem[2] = encode(OP_HALT, 2'd0, 2'd0, 8'h00);
    rf_exp.push_back('{2'd1, 8'h5A});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    check("st_exec_we", bus.dmem_we, 1'b1);
    reset = 1'b0;
    #1;
    check("abort_we", bus.dmem_we, 1'b0);
    check("abort_cs", bus.dmem_cs, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_pc", pc, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_idle_busy", busy, 1'b0);
    check("abort_idle_pc", pc, 8'h00);
    check("abort_idle_halted", halted, 1'b0);

    check("rf_queue_drained", rf_exp.size(), 0);
    check("dmem_queue_drained", dm_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
